// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with a one-entry
// holding buffer, so frames can run back to back with no idle gap.
// Optional build macro UART_TX_BREAK_EN adds a BREAK input and a BRK
// state that holds the line low for at least one full frame time.
module uart_tx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DIV_W-1:0]  BAUD_DIV,
  input  logic [3:0]        DATA_LEN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              STOP2,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              Data_Valid,
  output logic              Data_Ready,
`ifdef UART_TX_BREAK_EN
  input  logic              BREAK,
`endif
  output logic              TX_OUT,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BRK
`endif
  } state_t;

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [3:0]          bit_idx_reg, bit_idx_next;
  logic                stop_last_reg, stop_last_next;
  logic                tx_reg, tx_next;

  // Holding buffer and handshake
  logic [DATA_W-1:0]   hold_reg;
  logic                hold_full_reg;
  logic                ready_reg;
  logic                accept;

  // Per-frame configuration, captured when a frame (or break) begins
  logic [DIV_W-1:0]    div_reg;
  logic [3:0]          len_reg;
  logic                par_en_reg;
  logic                par_bit_reg;
  logic                stop2_reg;

  logic [3:0]          len_eff;
  logic [DATA_W-1:0]   len_mask;
  logic                par_live;
  logic                bit_end;
  logic                start_frame;
  logic                latch_cfg;

`ifdef UART_TX_BREAK_EN
  logic [4:0]          brk_left_reg, brk_left_next;
  logic [4:0]          frame_bits_live;
  logic                brk_start;
`endif

  // Out-of-range lengths fall back to the full data width
  always_comb begin
    if (DATA_LEN < 4'd5 || int'(DATA_LEN) > DATA_W) begin
      len_eff = 4'(DATA_W);
    end else begin
      len_eff = DATA_LEN;
    end
  end

  // Parity only covers the bits that will actually be sent
  assign len_mask = ~({DATA_W{1'b1}} << len_eff);
  assign par_live = (^(hold_reg & len_mask)) ^ PAR_TYP;
  assign bit_end  = (cnt_reg == '0);
  assign accept   = Data_Valid & ready_reg;

`ifdef UART_TX_BREAK_EN
  // Minimum break length: start + data + parity + stop bits
  assign frame_bits_live = 5'd1 + 5'(len_eff) + 5'(PAR_EN) + (STOP2 ? 5'd2 : 5'd1);
`endif

  // Next-state, next-bit and counter logic
  always_comb begin
    state_next     = state_reg;
    cnt_next       = (cnt_reg != '0) ? cnt_reg - DIV_W'(1) : cnt_reg;
    shift_next     = shift_reg;
    bit_idx_next   = bit_idx_reg;
    stop_last_next = stop_last_reg;
    tx_next        = tx_reg;
    start_frame    = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_start      = 1'b0;
    brk_left_next  = brk_left_reg;
`endif

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (BREAK) begin
          brk_start = 1'b1;
        end else
`endif
        if (hold_full_reg) begin
          start_frame = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_next   = DATA;
          tx_next      = shift_reg[0];
          cnt_next     = div_reg;
          bit_idx_next = 4'd0;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_next = div_reg;
          if (bit_idx_reg == len_reg - 4'd1) begin
            if (par_en_reg) begin
              state_next = PARITY;
              tx_next    = par_bit_reg;
            end else begin
              state_next     = STOP;
              tx_next        = 1'b1;
              stop_last_next = !stop2_reg;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_next     = STOP;
          tx_next        = 1'b1;
          cnt_next       = div_reg;
          stop_last_next = !stop2_reg;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (!stop_last_reg) begin
            stop_last_next = 1'b1;
            cnt_next       = div_reg;
            tx_next        = 1'b1;
          end else if (hold_full_reg) begin
            start_frame = 1'b1;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      BRK: begin
        if (bit_end) begin
          cnt_next = div_reg;
          if (brk_left_reg > 5'd1) begin
            brk_left_next = brk_left_reg - 5'd1;
          end else if (!BREAK) begin
            // One mark bit, then the usual stop-bit exit decides what follows
            state_next     = STOP;
            tx_next        = 1'b1;
            stop_last_next = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    if (start_frame) begin
      state_next = START;
      tx_next    = 1'b0;
      cnt_next   = BAUD_DIV;
      shift_next = hold_reg;
    end

`ifdef UART_TX_BREAK_EN
    if (brk_start) begin
      state_next    = BRK;
      tx_next       = 1'b0;
      cnt_next      = BAUD_DIV;
      brk_left_next = frame_bits_live;
    end
    latch_cfg = start_frame | brk_start;
`else
    latch_cfg = start_frame;
`endif
  end

  // FSM, shifter and line register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      bit_idx_reg   <= 4'd0;
      stop_last_reg <= 1'b0;
      tx_reg        <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      bit_idx_reg   <= bit_idx_next;
      stop_last_reg <= stop_last_next;
      tx_reg        <= tx_next;
    end
  end

`ifdef UART_TX_BREAK_EN
  // Remaining bit times of the minimum break
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      brk_left_reg <= 5'd0;
    end else begin
      brk_left_reg <= brk_left_next;
    end
  end
`endif

  // Frame configuration snapshot so mid-frame changes only hit the next frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_reg     <= '0;
      len_reg     <= 4'(DATA_W);
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      stop2_reg   <= 1'b0;
    end else if (latch_cfg) begin
      div_reg     <= BAUD_DIV;
      len_reg     <= len_eff;
      par_en_reg  <= PAR_EN;
      par_bit_reg <= par_live;
      stop2_reg   <= STOP2;
    end
  end

  // Holding buffer: filled on handshake, emptied when the shifter loads.
  // Ready drops on the accepting edge itself so a second word cannot slip in.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      ready_reg     <= 1'b1;
    end else begin
      ready_reg <= accept ? 1'b0 : !hold_full_reg;
      if (start_frame) begin
        hold_full_reg <= 1'b0;
      end else if (accept) begin
        hold_full_reg <= 1'b1;
        hold_reg      <= P_DATA;
      end
    end
  end

  assign TX_OUT     = tx_reg;
  assign Data_Ready = ready_reg;
  assign busy       = (state_reg != IDLE) | hold_full_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: table of single frames plus hand-written
// sequences for latency, back-to-back frames, mid-frame config change,
// mid-frame reset and (with UART_TX_BREAK_EN) break generation.
module tb_uart_tx_cfg;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [DIV_W-1:0]  BAUD_DIV = '0;
  logic [3:0]        DATA_LEN = 4'd8;
  logic              PAR_EN = 1'b0;
  logic              PAR_TYP = 1'b0;
  logic              STOP2 = 1'b0;
  logic [DATA_W-1:0] P_DATA = '0;
  logic              Data_Valid = 1'b0;
  logic              Data_Ready;
  logic              TX_OUT;
  logic              busy;
`ifdef UART_TX_BREAK_EN
  logic              BREAK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_cfg #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BAUD_DIV   (BAUD_DIV),
    .DATA_LEN   (DATA_LEN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Data_Ready (Data_Ready),
`ifdef UART_TX_BREAK_EN
    .BREAK      (BREAK),
`endif
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Expected line sequence is LSB first: bit 0 = start bit
  typedef struct {
    logic [15:0] div;
    logic [3:0]  len;
    logic        par_en;
    logic        par_typ;
    logic        stop2;
    logic [7:0]  data;
    int          nbits;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge CLK);
    P_DATA     = d;
    Data_Valid = 1'b1;
    while (Data_Ready !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("handshake ready", Data_Ready, 1);
    if (Data_Ready === 1'b1) begin
      @(posedge CLK);
      #1;
    end
    Data_Valid = 1'b0;
  endtask

  // Waits for the start bit, then checks every clock of nbits bit times
  task automatic check_frame(input string name, input logic [31:0] exp, input int nbits,
                             input int div, input bit chk_idle);
    int n;
    int glitch;
    int busy_bad;
    int b;
    logic [31:0] act;
    n = 0; glitch = 0; busy_bad = 0; act = '0;
    do begin
      @(negedge CLK);
      n++;
    end while (TX_OUT !== 1'b0 && n < 400);
    chk({name, " start seen"}, TX_OUT, 0);
    if (TX_OUT !== 1'b0) return;
    for (int k = 0; k < nbits * (div + 1); k++) begin
      if (k > 0) @(negedge CLK);
      b = k / (div + 1);
      if (k % (div + 1) == 0) act[b] = TX_OUT;
      else if (TX_OUT !== act[b]) glitch++;
      if (busy !== 1'b1) busy_bad++;
    end
    chk({name, " wave"}, act, exp);
    chk({name, " bit stable"}, glitch, 0);
    chk({name, " busy in frame"}, busy_bad, 0);
    if (chk_idle) begin
      @(negedge CLK);
      chk({name, " busy after"}, busy, 0);
      chk({name, " idle line"}, TX_OUT, 1);
    end
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [3:0] len, input logic pe,
                         input logic pt, input logic s2);
    BAUD_DIV = div; DATA_LEN = len; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
  endtask

  initial begin
    int n;
    int bad;

    //           div    len    pe    pt    s2    data    nbits exp
    vecs[0] = '{16'd3, 4'd8,  1'b0, 1'b0, 1'b0, 8'hA5, 10, 32'h34A};
    vecs[1] = '{16'd1, 4'd7,  1'b1, 1'b1, 1'b0, 8'h55, 10, 32'h3AA};
    vecs[2] = '{16'd1, 4'd7,  1'b1, 1'b0, 1'b0, 8'h55, 10, 32'h2AA};
    vecs[3] = '{16'd1, 4'd8,  1'b0, 1'b0, 1'b1, 8'h00, 11, 32'h600};
    vecs[4] = '{16'd0, 4'd3,  1'b1, 1'b0, 1'b0, 8'hC3, 11, 32'h586};
    vecs[5] = '{16'd2, 4'd5,  1'b1, 1'b0, 1'b0, 8'hFF, 8,  32'h0FE};
    vecs[6] = '{16'd0, 4'd12, 1'b1, 1'b1, 1'b0, 8'h81, 11, 32'h702};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset TX_OUT", TX_OUT, 1);
    chk("reset busy", busy, 0);
    chk("reset Data_Ready", Data_Ready, 1);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Latency from acceptance: line falls one clock later, ready returns after load
    set_cfg(16'd3, 4'd8, 1'b0, 1'b0, 1'b0);
    send_word(8'hA5);
    @(negedge CLK);
    chk("lat line still idle", TX_OUT, 1);
    chk("lat busy on accept", busy, 1);
    chk("lat ready low on accept", Data_Ready, 0);
    @(negedge CLK);
    chk("lat start bit", TX_OUT, 0);
    chk("lat ready low at load", Data_Ready, 0);
    @(negedge CLK);
    chk("lat ready back", Data_Ready, 1);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("lat frame done", busy, 0);

    // Table of single frames
    for (int i = 0; i < 7; i++) begin
      set_cfg(vecs[i].div, vecs[i].len, vecs[i].par_en, vecs[i].par_typ, vecs[i].stop2);
      send_word(vecs[i].data);
      check_frame($sformatf("vec%0d", i), vecs[i].exp, vecs[i].nbits, int'(vecs[i].div), 1'b1);
    end

    // Back-to-back words: second start bit follows first stop bit directly
    set_cfg(16'd0, 4'd8, 1'b0, 1'b0, 1'b0);
    fork
      begin
        send_word(8'h0F);
        send_word(8'hF0);
      end
      check_frame("b2b", {12'h0, 10'h3E0, 10'h21E}, 20, 0, 1'b1);
    join

    // Two stop bits latched at frame start survive a mid-frame change
    set_cfg(16'd1, 4'd8, 1'b0, 1'b0, 1'b1);
    send_word(8'h00);
    fork
      check_frame("stop2 latched", 32'h600, 11, 1, 1'b1);
      begin
        repeat (6) @(negedge CLK);
        STOP2 = 1'b0;
      end
    join
    send_word(8'h00);
    check_frame("stop1 next", 32'h200, 10, 1, 1'b1);

    // Reset during data bit 3 with a second word pending
    set_cfg(16'd1, 4'd8, 1'b0, 1'b0, 1'b0);
    fork
      begin
        send_word(8'h34);
        send_word(8'h11);
      end
      begin
        n = 0;
        do begin
          @(negedge CLK);
          n++;
        end while (TX_OUT !== 1'b0 && n < 400);
        repeat (8) @(negedge CLK);
        chk("rst at data bit3 low", TX_OUT, 0);
        RST = 1'b1;
        #1;
        chk("rst async TX_OUT", TX_OUT, 1);
        chk("rst async busy", busy, 0);
        chk("rst async Data_Ready", Data_Ready, 1);
      end
    join
    @(negedge CLK);
    RST = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rst pending discarded", bad, 0);
    send_word(8'h96);
    check_frame("after rst", 32'h32C, 10, 1, 1'b1);

`ifdef UART_TX_BREAK_EN
    // Short break still lasts one frame, then one mark bit, then pending data
    set_cfg(16'd0, 4'd8, 1'b0, 1'b0, 1'b0);
    fork
      begin
        @(negedge CLK);
        BREAK = 1'b1;
        repeat (2) @(negedge CLK);
        BREAK = 1'b0;
      end
      send_word(8'h5A);
      check_frame("break", {11'h0, 10'h2B4, 1'b1, 10'h0}, 21, 0, 1'b1);
    join
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised next-generation UART transmitter for the system's UART block.
- Runtime-configurable data length, parity, stop bits and baud divider.
- One-entry holding buffer with ready/valid handshake, so frames go back-to-back with no idle gap.
- Driven by the register-file/FIFO side; TX_OUT goes to the pad.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..9)
DIV_W, 16, width of baud divider input

Ports:
CLK  input  1  system/UART clock
RST  input  1  asynchronous, active-high reset
BAUD_DIV  input  DIV_W  clock cycles per bit minus 1 (0 = 1 clk/bit)
DATA_LEN  input  4  data bits per frame; values <5 or >DATA_W treated as DATA_W
PAR_EN  input  1  1 = parity bit inserted
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  1 = two stop bits, 0 = one
P_DATA  input  DATA_W  parallel data; bit 0 sent first
Data_Valid  input  1  producer has data
Data_Ready  output  1  holding register empty
TX_OUT  output  1  serial line, registered, idle high
busy  output  1  frame in progress or data pending

Behaviour:
Reset (async, RST=1):
- TX_OUT=1, busy=0, Data_Ready=1; state IDLE; holding register empty; counters 0.

Handshake:
- Transfer occurs on a rising edge with Data_Valid & Data_Ready; P_DATA is copied to the holding register.
- Data_Ready = !hold_full, registered.
- Data_Valid while Data_Ready=0 is ignored; the producer holds it.
- The holding register is freed on the edge the FSM moves it into the shifter (entry to START). Data_Ready rises the following cycle.
- Acceptance and shifter load never occur on the same edge.

Configuration:
- BAUD_DIV, DATA_LEN, PAR_EN, PAR_TYP and STOP2 are latched at START entry.
- Changes mid-frame affect only the next frame.

Bit timing:
- Bit counter loads BAUD_DIV at each bit start and decrements.
- A bit ends when the counter reaches 0, so each bit lasts BAUD_DIV+1 clocks.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1. If hold_full → START. TX_OUT falls one clock after acceptance when idle.
- START: TX_OUT=0 for one bit → DATA.
- DATA: sends latched bits LSB first, DATA_LEN bits. Then → PARITY if PAR_EN, else → STOP.
- PARITY: TX_OUT = XOR of the DATA_LEN sent bits, XOR PAR_TYP, for one bit → STOP.
- STOP: TX_OUT=1 for 1 or 2 bits. At the end of the last stop-bit clock:
  - hold_full → START directly (no gap);
  - otherwise → IDLE.

Outputs and boundary conditions:
- Parity is computed over the masked data only; bits above DATA_LEN are ignored.
- busy = (state != IDLE) | hold_full. It deasserts the cycle after the final stop bit when no data is pending.
- RST mid-frame aborts immediately: TX_OUT=1 and pending data is discarded.
- BAUD_DIV=0: every state lasts exactly one clock.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input port BREAK (1 bit) and state BRK.
  - In IDLE, BREAK=1 takes priority over pending data → BRK.
  - BRK drives TX_OUT=0 for as long as BREAK=1, with a minimum of one full frame: 1 start + DATA_LEN + parity + stop bits, in bit times.
  - After BREAK falls and the minimum has elapsed → STOP for one bit (mark) → normal STOP exit rules.
  - busy=1 in BRK.
  - BREAK is ignored outside IDLE.
- Undefined: no BREAK port, no BRK state.

Test Plan:
1. BAUD_DIV=3, DATA_LEN=8, PAR_EN=0, STOP2=0; send 0xA5 → TX_OUT: 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 4 clks, 40 clks total; busy high throughout, low next cycle.
2. DATA_LEN=7, PAR_EN=1, PAR_TYP=1, P_DATA=0x55 → 7 data bits 1,0,1,0,1,0,1, parity bit=1, 1 stop bit.
   - Repeat with PAR_TYP=0 → parity bit=0.
3. Two words 0x0F, 0xF0 presented back-to-back, BAUD_DIV=0 → second accepted during the first frame. Its start bit immediately follows the first stop bit: 20 contiguous clocks with no extra idle cycle.
4. STOP2=1, BAUD_DIV=1, 0x00 → stop high for 4 clks. Change STOP2 to 0 mid-frame → current frame still has 2 stop bits; next frame has 1.
5. Assert RST during data bit 3 → TX_OUT=1, busy=0, Data_Ready=1 asynchronously. The next accepted word transmits correctly.
6. (UART_TX_BREAK_EN) BREAK=1 for 2 clks in IDLE, DATA_LEN=8, PAR_EN=0, BAUD_DIV=0 → TX_OUT low 10 clks, then high 1 clk. Pending data then starts.
